// File: rtl/operand_packer_pkg.sv
// rtl/operand_packer_pkg.sv - shared sizing helpers and FSM state type for the operand packer
package operand_pkg;

    function automatic int slots(input int e);
        return 1 << e;
    endfunction

    // A single-slot frame still needs a one-bit slot counter.
    function automatic int cnt_w(input int e);
        return (e == 0) ? 1 : e;
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/operand_packer_if.sv
// rtl/operand_packer_if.sv - operand stream in, packed frame out
interface operand_packer_if
    import operand_pkg::*;
#(
    parameter int EXPONENT   = 4,
    parameter int DATA_WIDTH = 4
);
    localparam int N = slots(EXPONENT);

    logic                           s_valid;
    logic                           s_ready;
    logic [DATA_WIDTH-1:0]          s_data;
    logic                           s_last;
    logic                           m_valid;
    logic                           m_ready;
    logic [N-1:0][DATA_WIDTH-1:0]   m_vector;
    logic [EXPONENT:0]              m_count;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_vector, m_count
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_vector, m_count
    );
endinterface

// File: rtl/operand_packer.sv
// rtl/operand_packer.sv - packs 2**EXPONENT operands per frame, zero-padding short frames
module operand_packer
    import operand_pkg::*;
#(
    parameter int EXPONENT   = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_packer_if.slave  bus
);
    localparam int N   = slots(EXPONENT);
    localparam int CW  = cnt_w(EXPONENT);
    localparam int MCW = EXPONENT + 1;

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    vec_t            fill;
    vec_t            fill_next;
    logic            m_valid_q;
    vec_t            m_vector_q;
    logic [MCW-1:0]  m_count_q;
    logic [MCW-1:0]  count_out;
    logic            out_free;
    logic            beat;
    logic            completing;

    assign bus.s_ready  = (state == FILL);
    assign bus.m_valid  = m_valid_q;
    assign bus.m_vector = m_vector_q;
    assign bus.m_count  = m_count_q;

    always_comb begin
        out_free   = !m_valid_q || bus.m_ready;
        beat       = bus.s_valid && (state == FILL);
        completing = beat && ((cnt == CW'(N - 1)) || bus.s_last);
        count_out  = MCW'(cnt) + MCW'(1);
        fill_next  = fill;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == cnt) begin
                fill_next[i] = bus.s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            fill       <= '0;
            m_valid_q  <= 1'b0;
            m_vector_q <= '0;
            m_count_q  <= '0;
        end else begin
            // Any frame load below overrides this drain in the same edge.
            if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (beat) begin
                        if (completing && out_free) begin
                            m_valid_q  <= 1'b1;
                            m_vector_q <= fill_next;
                            m_count_q  <= count_out;
                            fill       <= '0;
                            cnt        <= '0;
                        end else if (completing) begin
                            fill  <= fill_next;
                            state <= HOLD;
                        end else begin
                            fill <= fill_next;
                            cnt  <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        m_valid_q  <= 1'b1;
                        m_vector_q <= fill;
                        m_count_q  <= count_out;
                        fill       <= '0;
                        cnt        <= '0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_packer.sv
// tb/tb_operand_packer.sv - randomized and directed checks of operand_packer at EXPONENT 2 and 0
module tb_operand_packer;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_packer_if #(.EXPONENT(2), .DATA_WIDTH(DW)) bus2 ();
    operand_packer_if #(.EXPONENT(0), .DATA_WIDTH(DW)) bus0 ();

    operand_packer #(.EXPONENT(2), .DATA_WIDTH(DW)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );
    operand_packer #(.EXPONENT(0), .DATA_WIDTH(DW)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Index 0 is the EXPONENT=0 instance, index 1 the EXPONENT=2 instance.
    logic        o_mv [2];
    logic        o_sr [2];
    logic [63:0] o_vec[2];
    logic [63:0] o_cnt[2];
    always_comb begin
        o_mv[0]  = bus0.m_valid;
        o_sr[0]  = bus0.s_ready;
        o_vec[0] = 64'(bus0.m_vector);
        o_cnt[0] = 64'(bus0.m_count);
        o_mv[1]  = bus2.m_valid;
        o_sr[1]  = bus2.s_ready;
        o_vec[1] = 64'(bus2.m_vector);
        o_cnt[1] = 64'(bus2.m_count);
    end

    // Reference: frames are lists of operands; a frame is outstanding from its completing
    // beat until the consumer takes it. At most one sits in the output and one waits behind it.
    logic [63:0] ring_vec[2][4];
    int          ring_cnt[2][4];
    int          head[2] = '{0, 0};
    int          tail[2] = '{0, 0};
    logic [63:0] cur_vec[2] = '{64'd0, 64'd0};
    int          cur_n[2] = '{0, 0};

    function automatic int nslots(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            string nm;
            int    outst;
            nm = (k == 0) ? "e0" : "e2";
            if (!rst_n) begin
                check({nm, " rst m_valid"},  64'(o_mv[k]), 64'd0);
                check({nm, " rst s_ready"},  64'(o_sr[k]), 64'd1);
                check({nm, " rst m_vector"}, o_vec[k], 64'd0);
                check({nm, " rst m_count"},  o_cnt[k], 64'd0);
                head[k]    = 0;
                tail[k]    = 0;
                cur_vec[k] = 64'd0;
                cur_n[k]   = 0;
            end else begin
                outst = tail[k] - head[k];
                check({nm, " m_valid"}, 64'(o_mv[k]), 64'(outst > 0));
                check({nm, " s_ready"}, 64'(o_sr[k]), 64'(outst < 2));
                if (outst > 0) begin
                    check({nm, " m_vector"}, o_vec[k], ring_vec[k][head[k] % 4]);
                    check({nm, " m_count"},  o_cnt[k], 64'(ring_cnt[k][head[k] % 4]));
                end
                if (o_mv[k] && bus2.m_ready) begin
                    head[k]++;
                end
                if (bus2.s_valid && o_sr[k]) begin
                    cur_vec[k] = cur_vec[k] | (64'(bus2.s_data) << (DW * cur_n[k]));
                    cur_n[k]++;
                    if (cur_n[k] == nslots(k) || bus2.s_last) begin
                        ring_vec[k][tail[k] % 4] = cur_vec[k];
                        ring_cnt[k][tail[k] % 4] = cur_n[k];
                        tail[k]++;
                        cur_vec[k] = 64'd0;
                        cur_n[k]   = 0;
                    end
                end
            end
        end
    end

    logic mr_lvl = 1'b1;

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic mr);
        bus2.s_valid = v;  bus2.s_data = d;  bus2.s_last = l;  bus2.m_ready = mr;
        bus0.s_valid = v;  bus0.s_data = d;  bus0.s_last = l;  bus0.m_ready = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds one beat on both inputs until instance k accepts it; returns just after that edge.
    task automatic send(input int k, input logic [DW-1:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        drive(1'b1, d, l, mr_lvl);
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = (k == 0) ? bus0.s_ready : bus2.s_ready;
            tick();
        end
        if (!acc) check("send timeout", 64'(acc), 64'd1);
        drive(1'b0, '0, 1'b0, mr_lvl);
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0, mr_lvl);
        repeat (n) tick();
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Full frame, then a short frame that must not carry residue.
        mr_lvl = 1'b1;
        for (int i = 1; i <= 4; i++) send(1, DW'(i), 1'b0);
        check("t1 m_vector", 64'(bus2.m_vector), 64'h4321);
        check("t1 m_count",  64'(bus2.m_count),  64'd4);
        send(1, 4'd5, 1'b0);
        send(1, 4'd6, 1'b1);
        check("t2 m_vector", 64'(bus2.m_vector), 64'h0065);
        check("t2 m_count",  64'(bus2.m_count),  64'd2);
        idle(3);

        // Back-pressure: one frame in the output, one in HOLD.
        mr_lvl = 1'b0;
        idle(1);
        for (int i = 1; i <= 8; i++) send(1, DW'(i), 1'b0);
        check("t3 s_ready held", 64'(bus2.s_ready), 64'd0);
        check("t3 head frame",   64'(bus2.m_vector), 64'h4321);
        mr_lvl = 1'b1;
        idle(2);
        mr_lvl = 1'b0;
        idle(2);
        check("t3 s_ready after", 64'(bus2.s_ready), 64'd1);
        mr_lvl = 1'b1;
        idle(3);

        // Streaming at full rate.
        for (int i = 0; i < 16; i++) send(1, DW'(i), 1'b0);
        idle(3);

        // Reset discards a partial frame.
        send(1, 4'd1, 1'b0);
        send(1, 4'd2, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(1, 4'd9, 1'b0);
        check("t5 m_vector", 64'(bus2.m_vector), 64'h9999);
        check("t5 m_count",  64'(bus2.m_count),  64'd4);
        idle(3);

        // Single-slot instance under back-pressure.
        mr_lvl = 1'b0;
        idle(1);
        send(0, 4'd7, 1'b0);
        check("t6 m_vector", 64'(bus0.m_vector), 64'h7);
        check("t6 m_count",  64'(bus0.m_count),  64'd1);
        send(0, 4'd3, 1'b0);
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        repeat (3) tick();
        check("t6 stall", 64'(bus0.s_ready), 64'd0);
        mr_lvl = 1'b1;
        idle(4);

        // Random traffic with varying back-pressure.
        for (int i = 0; i < 3000; i++) begin
            logic mr;
            if (i < 1500) mr = 1'($urandom_range(0, 1));
            else          mr = 1'(($urandom % 4) != 0);
            drive(1'(($urandom % 4) != 0), DW'($urandom), 1'(($urandom % 6) == 0), mr);
            tick();
        end
        mr_lvl = 1'b1;
        idle(10);
        check("e0 drained", 64'(tail[0] - head[0]), 64'd0);
        check("e2 drained", 64'(tail[1] - head[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
